// File: rtl/scan_mux_pkg.sv
// Shared definitions for the scan_mux family of registered channel multiplexers.
// Mode encodings live here so that future multi-mode variants can extend them in one place.
package scan_mux_pkg;

  localparam logic MODE_MANUAL = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  function automatic logic is_scan(input logic mode);
    return (mode == MODE_SCAN);
  endfunction

endpackage

// File: rtl/dwell_counter.sv
// Dwell counter for scan mode: counts held cycles and flags the terminal cycle.
// A dwell of zero behaves as one; the counter is cleared whenever scanning is disabled.
module dwell_counter #(
  parameter int DW = 8
) (
  input  logic          clock,
  input  logic          clear,
  input  logic          enable,
  input  logic [DW-1:0] dwell,
  output logic          tick
);

  logic [DW-1:0] cnt_r;
  logic [DW-1:0] terminal_s;

  // Terminal count is max(dwell,1)-1; a shortened dwell mid-scan may wrap the counter first.
  always_comb begin
    terminal_s = {DW{1'b0}};
    if (dwell == {DW{1'b0}}) begin
      terminal_s = {DW{1'b0}};
    end else begin
      terminal_s = dwell - DW'(1);
    end
    tick = enable && (cnt_r == terminal_s);
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      cnt_r <= {DW{1'b0}};
    end else if (!enable || tick) begin
      cnt_r <= {DW{1'b0}};
    end else begin
      cnt_r <= cnt_r + DW'(1);
    end
  end

endmodule

// File: rtl/scan_mux.sv
// N-channel registered multiplexer with manual select and round-robin scan modes.
// out and out_ch are loaded from the same next-channel value, so they always agree.
module scan_mux
  import scan_mux_pkg::*;
#(
  parameter  int N  = 4,
  parameter  int W  = 8,
  parameter  int DW = 8,
  localparam int SW = $clog2(N)
) (
  input  logic            clock,
  input  logic            clear,
  input  logic [N*W-1:0]  in_bus,
  input  logic            mode,
  input  logic [SW-1:0]   sel,
  input  logic [DW-1:0]   dwell,
  output logic [W-1:0]    out,
  output logic [SW-1:0]   out_ch,
  output logic            out_valid,
  output logic            switched
);

  logic [SW-1:0] ch_r;
  logic [SW-1:0] ch_next_s;
  logic [W-1:0]  chan_s [N];
  logic [W-1:0]  data_next_s;
  logic          scan_s;
  logic          tick_s;
  logic          sel_legal_s;

  assign scan_s      = is_scan(mode);
  assign sel_legal_s = ({{(32-SW){1'b0}}, sel} < 32'(N));

  for (genvar g = 0; g < N; g++) begin : g_unpack
    assign chan_s[g] = in_bus[g*W +: W];
  end

  dwell_counter #(
    .DW(DW)
  ) u_dwell (
    .clock  (clock),
    .clear  (clear),
    .enable (scan_s),
    .dwell  (dwell),
    .tick   (tick_s)
  );

  // Next channel: out-of-range manual selects hold the current channel.
  always_comb begin
    ch_next_s = ch_r;
    if (scan_s) begin
      if (!tick_s) begin
        ch_next_s = ch_r;
      end else if (ch_r == SW'(N-1)) begin
        ch_next_s = {SW{1'b0}};
      end else begin
        ch_next_s = ch_r + SW'(1);
      end
    end else begin
      if (sel_legal_s) begin
        ch_next_s = sel;
      end else begin
        ch_next_s = ch_r;
      end
    end
  end

  always_comb begin
    data_next_s = {W{1'b0}};
    for (int k = 0; k < N; k++) begin
      if (ch_next_s == SW'(k)) begin
        data_next_s = chan_s[k];
      end else begin
        data_next_s = data_next_s;
      end
    end
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      ch_r      <= {SW{1'b0}};
      out       <= {W{1'b0}};
      switched  <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      ch_r      <= ch_next_s;
      out       <= data_next_s;
      switched  <= (ch_next_s != ch_r);
      out_valid <= 1'b1;
    end
  end

  assign out_ch = ch_r;

endmodule

// File: tb/tb_scan_mux.sv
// Bench for scan_mux: N=4 and N=3 instances share stimulus and are checked every cycle
// against a behavioural model, with directed literal checks pinning the model itself.
module tb_scan_mux;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] in_bus;
  logic        mode;
  logic [1:0]  sel;
  logic [7:0]  dwell;

  logic [7:0] out_a, out_b;
  logic [1:0] ch_a, ch_b;
  logic       val_a, val_b, sw_a, sw_b;

  int checks = 0;
  int errors = 0;

  int m_ch[2], m_cnt[2], m_out[2], m_sw[2], m_val[2];
  int n_of[2] = '{4, 3};

  localparam logic [7:0] DTAB [6] = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd4, 8'd7};
  int exp_ch[15] = '{3, 3, 0, 0, 0, 1, 1, 1, 2, 2, 2, 3, 3, 3, 0};
  int exp_sw[15] = '{0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1, 0, 0, 1};

  always #5 clock = ~clock;

  scan_mux #(.N(4), .W(8), .DW(8)) dut_a (
    .clock(clock), .clear(clear), .in_bus(in_bus), .mode(mode), .sel(sel), .dwell(dwell),
    .out(out_a), .out_ch(ch_a), .out_valid(val_a), .switched(sw_a)
  );

  scan_mux #(.N(3), .W(8), .DW(8)) dut_b (
    .clock(clock), .clear(clear), .in_bus(in_bus[23:0]), .mode(mode), .sel(sel), .dwell(dwell),
    .out(out_b), .out_ch(ch_b), .out_valid(val_b), .switched(sw_b)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int chan_data(input int k);
    return int'((in_bus >> (k * 8)) & 32'hFF);
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_ch[i] = 0; m_cnt[i] = 0; m_out[i] = 0; m_sw[i] = 0; m_val[i] = 0;
    end
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int nxt;
      int term;
      term = (dwell == 8'd0) ? 1 : int'(dwell);
      if (mode == 1'b0) begin
        nxt = (int'(sel) < n_of[i]) ? int'(sel) : m_ch[i];
        m_cnt[i] = 0;
      end else if (m_cnt[i] == term - 1) begin
        m_cnt[i] = 0;
        nxt = (m_ch[i] + 1) % n_of[i];
      end else begin
        m_cnt[i] = (m_cnt[i] + 1) % 256;
        nxt = m_ch[i];
      end
      m_sw[i]  = (nxt != m_ch[i]) ? 1 : 0;
      m_ch[i]  = nxt;
      m_out[i] = chan_data(nxt);
      m_val[i] = 1;
    end
  endtask

  task automatic compare_all();
    chk("out_a", int'(out_a), m_out[0]);
    chk("out_ch_a", int'(ch_a), m_ch[0]);
    chk("valid_a", int'(val_a), m_val[0]);
    chk("switched_a", int'(sw_a), m_sw[0]);
    chk("out_b", int'(out_b), m_out[1]);
    chk("out_ch_b", int'(ch_b), m_ch[1]);
    chk("valid_b", int'(val_b), m_val[1]);
    chk("switched_b", int'(sw_b), m_sw[1]);
  endtask

  task automatic tick();
    @(posedge clock);
    if (clear) model_step();
    @(negedge clock);
    compare_all();
  endtask

  task automatic do_clear();
    clear = 1'b0;
    #1;
    model_reset();
    compare_all();
  endtask

  initial begin
    in_bus = $urandom();
    mode   = 1'b0;
    sel    = 2'd0;
    dwell  = 8'd3;
    clear  = 1'b0;
    #1;
    model_reset();
    compare_all();
    tick();
    in_bus = $urandom();
    tick();
    chk("rst_out", int'(out_a), 0);
    chk("rst_ch", int'(ch_a), 0);
    chk("rst_valid", int'(val_a), 0);
    chk("rst_sw", int'(sw_a), 0);

    // release with sel=2 carrying 8'hA5
    clear = 1'b1; mode = 1'b0; sel = 2'd2;
    in_bus = $urandom(); in_bus[23:16] = 8'hA5;
    tick();
    chk("rel_out", int'(out_a), 8'hA5);
    chk("rel_ch", int'(ch_a), 2);
    chk("rel_valid", int'(val_a), 1);
    chk("rel_sw", int'(sw_a), 1);
    chk("rel_out_b", int'(out_b), 8'hA5);

    sel = 2'd3; in_bus[31:24] = 8'h3C;
    tick();
    chk("sel3_out", int'(out_a), 8'h3C);
    chk("sel3_ch", int'(ch_a), 3);
    chk("sel3_sw", int'(sw_a), 1);
    chk("n3_illegal_ch", int'(ch_b), 2);
    chk("n3_illegal_sw", int'(sw_b), 0);
    tick();
    chk("sel3_again_sw", int'(sw_a), 0);
    in_bus[15:8] = ~in_bus[15:8];
    tick();
    chk("other_chan_out", int'(out_a), 8'h3C);

    // scan wrap with dwell=3 starting from channel 3
    mode = 1'b1; dwell = 8'd3;
    for (int e = 0; e < 15; e++) begin
      in_bus = $urandom();
      tick();
      chk("wrap_ch", int'(ch_a), exp_ch[e]);
      chk("wrap_sw", int'(sw_a), exp_sw[e]);
    end

    dwell = 8'd0;
    for (int e = 0; e < 4; e++) begin
      tick();
      chk("dw0_ch", int'(ch_a), (e + 1) % 4);
      chk("dw0_sw", int'(sw_a), 1);
    end
    dwell = 8'd1;
    for (int e = 0; e < 6; e++) begin
      tick();
      chk("dw1_ch", int'(ch_a), (e + 1) % 4);
      chk("dw1_sw", int'(sw_a), 1);
    end

    mode = 1'b0; sel = 2'd0;
    tick();
    chk("to_manual_ch", int'(ch_a), 0);
    mode = 1'b1; dwell = 8'd3;
    tick(); chk("to_scan_hold1", int'(ch_a), 0);
    tick(); chk("to_scan_hold2", int'(ch_a), 0);
    tick(); chk("to_scan_adv", int'(ch_a), 1);
    dwell = 8'd1;
    tick(); chk("pre_clear_ch", int'(ch_a), 2);

    do_clear();
    chk("mid_clr_out", int'(out_a), 0);
    chk("mid_clr_ch", int'(ch_a), 0);
    chk("mid_clr_valid", int'(val_a), 0);
    tick();
    clear = 1'b1; dwell = 8'd2;
    tick();
    chk("resume_ch", int'(ch_a), 0);
    chk("resume_valid", int'(val_a), 1);
    chk("resume_sw", int'(sw_a), 0);
    tick();
    chk("resume_adv", int'(ch_a), 1);

    for (int c = 0; c < 3000; c++) begin
      in_bus = $urandom();
      clear = 1'b1;
      if ($urandom_range(0, 19) == 0) mode = ~mode;
      if ($urandom_range(0, 3) == 0) sel = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) dwell = DTAB[$urandom_range(0, 5)];
      if ($urandom_range(0, 499) == 0) dwell = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 299) == 0) do_clear();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
